ov5640_data_capture: RTL and testbench



---
 rtl/ov5640_pkg.sv | 30 +++
 rtl/ov5640_data_capture_if.sv | 39 +++
 rtl/ov5640_sync_edge.sv | 44 ++++
 rtl/ov5640_data_capture.sv | 153 +++++++++++++++
 tb/tb_ov5640_data_capture.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ov5640_pkg.sv
// ov5640_pkg: shared definitions for the OV5640 DVP capture path.
//   state_t        capture FSM encoding (IDLE=0, SKIP=1, CAPTURE=2)
//   R_W/G_W/B_W    RGB565 field widths
//   rgb565_to_888  replicates the top bits of each 565 field into the low bits
//                  of the matching 8-bit field, so full scale stays full scale
package ov5640_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SKIP    = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  localparam int R_W      = 5;
  localparam int G_W      = 6;
  localparam int B_W      = 5;
  localparam int RGB565_W = R_W + G_W + B_W;
  localparam int RGB888_W = 24;

  function automatic logic [RGB888_W-1:0] rgb565_to_888(input logic [RGB565_W-1:0] pix);
    logic [R_W-1:0] r;
    logic [G_W-1:0] g;
    logic [B_W-1:0] b;
    r = pix[RGB565_W-1 -: R_W];
    g = pix[B_W +: G_W];
    b = pix[0 +: B_W];
    return {r, r[R_W-1 -: 3], g, g[G_W-1 -: 2], b, b[B_W-1 -: 3]};
  endfunction

endpackage

// File: rtl/ov5640_data_capture_if.sv
// ov5640_data_capture_if: DVP pins in, pixel write strobe out.
//   ov5640_vsync/href/data   camera DVP inputs (pixel-clock domain)
//   ov5640_wr_en             one-cycle strobe per captured pixel
//   ov5640_data_out          RGB888 {R,G,B}, meaningful only with ov5640_wr_en
//   frame_start              one-cycle pulse at each captured frame boundary
//   frame_cnt, line_err      statistics, present only with OV5640_CAPTURE_STATS_EN
// Handshake: ov5640_wr_en is a valid strobe with no ready; the sink has no
// way to stall and must accept every beat in the cycle it is presented.
// modport slave is the capture block, modport master is the camera/sink side.
interface ov5640_data_capture_if;

  logic        ov5640_vsync;
  logic        ov5640_href;
  logic [7:0]  ov5640_data;
  logic        ov5640_wr_en;
  logic [23:0] ov5640_data_out;
  logic        frame_start;
`ifdef OV5640_CAPTURE_STATS_EN
  logic [15:0] frame_cnt;
  logic        line_err;
`endif

  modport slave (
    input  ov5640_vsync, ov5640_href, ov5640_data,
`ifdef OV5640_CAPTURE_STATS_EN
    output frame_cnt, line_err,
`endif
    output ov5640_wr_en, ov5640_data_out, frame_start
  );

  modport master (
    output ov5640_vsync, ov5640_href, ov5640_data,
`ifdef OV5640_CAPTURE_STATS_EN
    input  frame_cnt, line_err,
`endif
    input  ov5640_wr_en, ov5640_data_out, frame_start
  );

endinterface

// File: rtl/ov5640_sync_edge.sv
// ov5640_sync_edge: single input register stage for the DVP pins plus edge
// detection on the registered signals.
//   clk, rst_n      pixel clock, synchronous active-low reset
//   vsync, href     raw DVP syncs
//   data            raw DVP byte
//   href_q, data_q  stage-1 registered line-valid and byte
//   vs_rise         stage-1 vsync went 0->1 (frame boundary)
//   href_fall       stage-1 href went 1->0 (line end)
module ov5640_sync_edge (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       href,
  input  logic [7:0] data,
  output logic       href_q,
  output logic [7:0] data_q,
  output logic       vs_rise,
  output logic       href_fall
);

  logic vsync_q;
  logic vsync_qq;
  logic href_qq;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_q  <= 1'b0;
      vsync_qq <= 1'b0;
      href_q   <= 1'b0;
      href_qq  <= 1'b0;
      data_q   <= 8'd0;
    end else begin
      vsync_q  <= vsync;
      vsync_qq <= vsync_q;
      href_q   <= href;
      href_qq  <= href_q;
      data_q   <= data;
    end
  end

  assign vs_rise   = vsync_q & ~vsync_qq;
  assign href_fall = ~href_q & href_qq;

endmodule

// File: rtl/ov5640_data_capture.sv
// ov5640_data_capture: OV5640 DVP -> SDRAM write-FIFO capture stage.
// Drops FRAME_SKIP whole frames after sys_init_done rises, then packs RGB565
// byte pairs into RGB888 words, one strobe per pixel, clipped to
// H_PIXEL x V_PIXEL per frame.
//   sys_clk        pixel clock (ov5640_pclk)
//   sys_rst_n      synchronous active-low reset
//   sys_init_done  camera/SDRAM init complete (level)
//   cam            DVP pins in, write strobe/data/frame_start out
//   dbg_state      current capture FSM state
// Optional macro OV5640_CAPTURE_STATS_EN adds frame_cnt and line_err.
module ov5640_data_capture
  import ov5640_pkg::*;
#(
  parameter int H_PIXEL    = 640,
  parameter int V_PIXEL    = 480,
  parameter int FRAME_SKIP = 10
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 sys_init_done,
  ov5640_data_capture_if.slave cam,
  output state_t               dbg_state
);

  localparam int PW = $clog2(H_PIXEL + 2);
  localparam int LW = $clog2(V_PIXEL + 1);
  localparam logic [PW-1:0] PIX_LIM  = PW'(H_PIXEL);
  localparam logic [PW-1:0] PIX_SAT  = PW'(H_PIXEL + 1);
  localparam logic [LW-1:0] LINE_LIM = LW'(V_PIXEL);
  localparam logic [15:0]   SKIP_N   = 16'(FRAME_SKIP);

  logic       href_q;
  logic [7:0] data_q;
  logic       vs_rise;
  logic       href_fall;

  ov5640_sync_edge u_sync (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .vsync     (cam.ov5640_vsync),
    .href      (cam.ov5640_href),
    .data      (cam.ov5640_data),
    .href_q    (href_q),
    .data_q    (data_q),
    .vs_rise   (vs_rise),
    .href_fall (href_fall)
  );

  state_t            state;
  logic [15:0]       skip_cnt;
  logic [15:0]       skip_next;
  logic [PW-1:0]     pix_cnt;
  logic [LW-1:0]     line_cnt;
  logic              phase;
  logic [7:0]        hi_byte;
  logic              wr_en;
  logic [RGB888_W-1:0] data_out;
  logic              frame_start;
  logic              boundary;
`ifdef OV5640_CAPTURE_STATS_EN
  logic [15:0]       frame_cnt;
  logic              line_err;
`endif

  assign skip_next = skip_cnt + 16'd1;

  // The vs_rise that ends SKIP is itself the first captured frame boundary,
  // so SKIP exit and every CAPTURE vs_rise share the same frame restart.
  assign boundary = vs_rise &&
                    ((state == CAPTURE) || (state == SKIP && skip_next >= SKIP_N));

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      skip_cnt    <= 16'd0;
      pix_cnt     <= '0;
      line_cnt    <= '0;
      phase       <= 1'b0;
      hi_byte     <= 8'd0;
      wr_en       <= 1'b0;
      data_out    <= '0;
      frame_start <= 1'b0;
`ifdef OV5640_CAPTURE_STATS_EN
      frame_cnt   <= 16'd0;
      line_err    <= 1'b0;
`endif
    end else begin
      wr_en       <= 1'b0;
      frame_start <= 1'b0;
      if (!sys_init_done) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            skip_cnt <= 16'd0;
            state    <= SKIP;
          end
          SKIP: begin
            if (vs_rise) begin
              skip_cnt <= skip_next;
              if (skip_next >= SKIP_N) state <= CAPTURE;
            end
          end
          CAPTURE: ;
          default: state <= IDLE;
        endcase

        if (boundary) begin
          // vs_rise takes priority over a coincident href_fall.
          pix_cnt     <= '0;
          line_cnt    <= '0;
          phase       <= 1'b0;
          frame_start <= 1'b1;
`ifdef OV5640_CAPTURE_STATS_EN
          frame_cnt   <= frame_cnt + 16'd1;
`endif
        end else if (state == CAPTURE) begin
          if (href_fall) begin
            // A dangling high byte is simply dropped with the phase reset.
            phase   <= 1'b0;
            pix_cnt <= '0;
            if (line_cnt < LINE_LIM) line_cnt <= line_cnt + LW'(1);
`ifdef OV5640_CAPTURE_STATS_EN
            if (pix_cnt != PIX_LIM) line_err <= 1'b1;
`endif
          end else if (href_q) begin
            phase <= ~phase;
            if (!phase) begin
              hi_byte <= data_q;
            end else begin
              if (pix_cnt < PIX_LIM && line_cnt < LINE_LIM) begin
                wr_en    <= 1'b1;
                data_out <= rgb565_to_888({hi_byte, data_q});
              end
              // Saturating one past the limit keeps over-long lines visible.
              if (pix_cnt < PIX_SAT) pix_cnt <= pix_cnt + PW'(1);
            end
          end
        end
      end
    end
  end

  assign cam.ov5640_wr_en    = wr_en;
  assign cam.ov5640_data_out = data_out;
  assign cam.frame_start     = frame_start;
`ifdef OV5640_CAPTURE_STATS_EN
  assign cam.frame_cnt       = frame_cnt;
  assign cam.line_err        = line_err;
`endif
  assign dbg_state           = state;

endmodule

// File: tb/tb_ov5640_data_capture.sv
// tb_ov5640_data_capture: directed bench for ov5640_data_capture with a small
// frame geometry (6 x 4 pixels, 2 skipped frames). Frames are driven as
// active lines followed by a vsync blanking pulse.
module tb_ov5640_data_capture;
  import ov5640_pkg::*;

  localparam int H    = 6;
  localparam int V    = 4;
  localparam int SKIP = 2;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   init_done = 1'b0;
  state_t dbg_state;

  always #5 clk = ~clk;

  ov5640_data_capture_if intf();

  ov5640_data_capture #(
    .H_PIXEL    (H),
    .V_PIXEL    (V),
    .FRAME_SKIP (SKIP)
  ) dut (
    .sys_clk       (clk),
    .sys_rst_n     (rst_n),
    .sys_init_done (init_done),
    .cam           (intf),
    .dbg_state     (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          failures = 0;
  int          strobe_cnt = 0;
  logic [23:0] exp_q[$];
  logic [23:0] mon_exp;
  int          vs_seen = 0;
  int          line_idx = 0;
  int          fs_exp_cnt = 0;
  bit          cap_on = 1'b0;

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [23:0] exp;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] exp_rgb(input logic [7:0] hi, input logic [7:0] lo);
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    r = hi[7:3];
    g = {hi[2:0], lo[7:5]};
    b = lo[4:0];
    return {r, r[4:2], g, g[5:4], b, b[4:2]};
  endfunction

  // Every strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (intf.ov5640_wr_en === 1'b1) begin
      strobe_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("pixel_data", {8'd0, intf.ov5640_data_out}, {8'd0, mon_exp});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    intf.ov5640_href = 1'b1;
    intf.ov5640_data = b;
  endtask

  task automatic end_line();
    @(negedge clk);
    intf.ov5640_href = 1'b0;
    intf.ov5640_data = 8'd0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    if (cap_on) line_idx++;
  endtask

  task automatic send_line(input int npix, input bit odd);
    logic [7:0] hi;
    logic [7:0] lo;
    for (int p = 0; p < npix; p++) begin
      hi = 8'($urandom_range(0, 255));
      lo = 8'($urandom_range(0, 255));
      send_byte(hi);
      send_byte(lo);
      if (cap_on && p < H && line_idx < V) exp_q.push_back(exp_rgb(hi, lo));
    end
    if (odd) send_byte(8'($urandom_range(0, 255)));
    end_line();
  endtask

  task automatic send_vsync();
    bit exp_fs;
    @(negedge clk);
    intf.ov5640_vsync = 1'b1;
    intf.ov5640_href  = 1'b0;
    vs_seen++;
    exp_fs = init_done && (vs_seen >= SKIP);
    @(negedge clk);
    check("frame_start_early", {31'd0, intf.frame_start}, 32'd0);
    @(negedge clk);
    check("frame_start", {31'd0, intf.frame_start}, {31'd0, exp_fs});
    if (exp_fs) begin
      fs_exp_cnt++;
      cap_on   = 1'b1;
      line_idx = 0;
    end
    @(negedge clk);
    check("frame_start_width", {31'd0, intf.frame_start}, 32'd0);
    @(negedge clk);
    intf.ov5640_vsync = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
  endtask

  task automatic send_frame(input int nlines, input int npix, input int exp_strobes,
                            input string name);
    int start;
    start = strobe_cnt;
    for (int l = 0; l < nlines; l++) send_line(npix, 1'b0);
    check(name, strobe_cnt - start, exp_strobes);
    check("drain", exp_q.size(), 32'd0);
    send_vsync();
  endtask

  task automatic check_stats(input logic exp_err);
`ifdef OV5640_CAPTURE_STATS_EN
    check("line_err", {31'd0, intf.line_err}, {31'd0, exp_err});
    check("frame_cnt", {16'd0, intf.frame_cnt}, fs_exp_cnt);
`else
    if (exp_err === 1'bx) check("stats_absent", 32'd0, 32'd1);
`endif
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int start;
    vecs[0] = '{8'hF8, 8'h00, 24'hFF0000};
    vecs[1] = '{8'h07, 8'hE0, 24'h00FF00};
    vecs[2] = '{8'h00, 8'h1F, 24'h0000FF};
    vecs[3] = '{8'hFF, 8'hFF, 24'hFFFFFF};
    vecs[4] = '{8'h84, 8'h10, 24'h848284};
    vecs[5] = '{8'h6B, 8'h4D, 24'h6B696B};

    intf.ov5640_vsync = 1'b0;
    intf.ov5640_href  = 1'b0;
    intf.ov5640_data  = 8'd0;

    // Reset values
    for (int i = 0; i < 3; i++) @(negedge clk);
    check("rst_wr_en", {31'd0, intf.ov5640_wr_en}, 32'd0);
    check("rst_data_out", {8'd0, intf.ov5640_data_out}, 32'd0);
    check("rst_frame_start", {31'd0, intf.frame_start}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    check_stats(1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_wait_init", {30'd0, dbg_state}, 32'd0);
    init_done = 1'b1;
    for (int i = 0; i < 3; i++) @(negedge clk);
    check("state_skip", {30'd0, dbg_state}, 32'd1);

    // Frame skip: two frames dropped, next two captured in full
    send_frame(V, H, 0, "skip_frame1");
    send_frame(V, H, 0, "skip_frame2");
    check("state_capture", {30'd0, dbg_state}, 32'd2);
    send_frame(V, H, H * V, "cap_frame3");
    send_frame(V, H, H * V, "cap_frame4");
    check_stats(1'b0);

    // Odd byte: dangling byte dropped, next line realigned at phase 0
    start = strobe_cnt;
    send_line(H, 1'b1);
    check("odd_line_strobes", strobe_cnt - start, H);
    start = strobe_cnt;
    send_line(H, 1'b0);
    check("after_odd_strobes", strobe_cnt - start, H);
    send_vsync();
    check_stats(1'b0);

    // Over-long frame: clipped to H per line and V lines
    send_frame(V + 2, H + 3, H * V, "overlong_frame");
    check_stats(1'b1);

    // Colour expansion table, one pixel per line, with latency checks
    for (int i = 0; i < 6; i++) begin
      if (line_idx >= V) send_vsync();
      send_byte(vecs[i].hi);
      send_byte(vecs[i].lo);
      exp_q.push_back(vecs[i].exp);
      @(negedge clk);
      intf.ov5640_href = 1'b0;
      check("latency_1cyc", {31'd0, intf.ov5640_wr_en}, 32'd0);
      @(negedge clk);
      check("latency_2cyc", {31'd0, intf.ov5640_wr_en}, 32'd1);
      check("colour", {8'd0, intf.ov5640_data_out}, {8'd0, vecs[i].exp});
      for (int k = 0; k < 3; k++) @(negedge clk);
      line_idx++;
    end
    send_vsync();

    // Init loss mid-line
    begin
      logic [7:0] hi;
      logic [7:0] lo;
      hi = 8'h5A;
      lo = 8'hC3;
      send_byte(hi);
      send_byte(lo);
      exp_q.push_back(exp_rgb(hi, lo));
      send_byte(8'h12);
      @(negedge clk);
      intf.ov5640_data = 8'h34;
      init_done = 1'b0;
      cap_on    = 1'b0;
      vs_seen   = 0;
      @(negedge clk);
      check("init_loss_wr_en", {31'd0, intf.ov5640_wr_en}, 32'd0);
      for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 255)));
      end_line();
      check("init_loss_drain", exp_q.size(), 32'd0);
      check("init_loss_state", {30'd0, dbg_state}, 32'd0);
    end
    init_done = 1'b1;
    for (int i = 0; i < 3; i++) @(negedge clk);
    send_frame(V, H, 0, "reinit_skip1");
    send_frame(V, H, 0, "reinit_skip2");
    send_frame(V, H, H * V, "reinit_cap");

    // Reset mid-frame
    send_line(H, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_wr_en", {31'd0, intf.ov5640_wr_en}, 32'd0);
    check("midrst_data_out", {8'd0, intf.ov5640_data_out}, 32'd0);
    check("midrst_frame_start", {31'd0, intf.frame_start}, 32'd0);
    check("midrst_state", {30'd0, dbg_state}, 32'd0);
    rst_n      = 1'b1;
    cap_on     = 1'b0;
    vs_seen    = 0;
    fs_exp_cnt = 0;
    line_idx   = 0;
    check_stats(1'b0);
    send_frame(V - 1, H, 0, "midrst_rest");
    send_frame(V, H, 0, "midrst_skip2");
    send_frame(V, H, H * V, "midrst_cap");
    check_stats(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Bound on total run time
  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
